fifo_wr_arbiter: RTL and testbench

Shares the write port of one fifo_sync instance between NUM_REQ pixel-stream requesters using valid/ready handshakes and round-robin arbitration with a per-grant burst limit. Each stored word is tagged with the source requester ID, so a downstream consumer can demultiplex. The read side exposes the FIFO with underflow protection. It sits between multiple image-processing stages and a single shared buffer.

---
 rtl/fifo_wr_arbiter_pkg.sv | 15 +
 rtl/fifo_sync.sv | 64 ++++++
 rtl/rr_priority_select.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the fifo_wr_arbiter block.
//   arb_state_t : arbiter FSM state encoding (IDLE / GRANT)
//   id_width()  : width of a requester ID, never less than one bit
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data.
// Ports:
//   clk, aresetn (synchronous, active-low)
//   wr_en/data_wr   write side, ignored while full
//   rd_en/data_rd   read side, ignored while empty; data_rd updates on the
//                   edge that accepts the read
//   data_count      occupancy, empty, full
module fifo_sync #(
  parameter  int WIDTH = 12,
  parameter  int SIZE  = 16,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_wr,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_rd,
  output logic [AW:0]      data_count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [SIZE];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] data_rd_reg;
  logic             do_wr;
  logic             do_rd;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == (AW+1)'(SIZE));
  assign do_wr      = wr_en & ~full;
  assign do_rd      = rd_en & ~empty;
  assign data_count = count_reg;
  assign data_rd    = data_rd_reg;

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= data_wr;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      data_rd_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        data_rd_reg <= mem[rd_ptr_reg];
      end
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker.
// Ports:
//   req    in  NUM_REQ  request vector
//   last   in  ID_W     index granted most recently (lowest priority now)
//   winner out ID_W     first requesting index after last, wrapping
//   any    out 1        at least one request present
module rr_priority_select #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  // Scan from the farthest candidate (last itself) to the nearest
  // (last+1) so the nearest requesting index is the one left standing.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    any    = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        winner = ID_W'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a shared FIFO. Each stored word is
// {requester ID, pixel data}; the read side returns both halves.
// Ports:
//   clk, aresetn        clock, synchronous active-low reset
//   req_valid/req_data  per-requester valid and packed data
//   req_ready           per-requester accept, one-hot or zero
//   rd_en               read request
//   data_rd/id_rd       registered read data and its source ID
//   data_count/empty/full  FIFO status
//   rd_underflow        sticky flag: read attempted while empty
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int DATA_W    = 10,
  parameter  int SIZE      = 16,
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 8,
  localparam int ID_W      = id_width(NUM_REQ),
  localparam int CNT_W     = $clog2(SIZE) + 1
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         data_rd,
  output logic [ID_W-1:0]           id_rd,
  output logic [CNT_W-1:0]          data_count,
  output logic                      empty,
  output logic                      full,
  output logic                      rd_underflow
);

  localparam int BURST_W = $clog2(MAX_BURST) + 1;

  arb_state_t         state_reg;
  logic [ID_W-1:0]    grant_reg;
  logic [ID_W-1:0]    last_grant_reg;
  logic [BURST_W-1:0] burst_cnt_reg;
  logic               rd_underflow_reg;

  logic [DATA_W-1:0]  req_word [NUM_REQ];
  logic [ID_W-1:0]    winner;
  logic               any_valid;
  logic               granted_valid;
  logic               transfer;
  logic               last_beat;
  logic [DATA_W+ID_W-1:0] fifo_wr_data;
  logic [DATA_W+ID_W-1:0] fifo_rd_data;

  // Unpack requester data and build the one-hot ready vector. Ready is a
  // function of registered state and the pre-edge full flag only.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_word[gi]  = req_data[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = (state_reg == GRANT) && (grant_reg == ID_W'(gi)) && !full;
    end
  endgenerate

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_select (
    .req    (req_valid),
    .last   (last_grant_reg),
    .winner (winner),
    .any    (any_valid)
  );

  assign granted_valid = req_valid[grant_reg];
  assign transfer      = (state_reg == GRANT) && granted_valid && !full;
  assign last_beat     = (burst_cnt_reg == BURST_W'(MAX_BURST - 1));
  assign fifo_wr_data  = {grant_reg, req_word[grant_reg]};

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      burst_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            grant_reg     <= winner;
            burst_cnt_reg <= '0;
            state_reg     <= GRANT;
          end
        end
        GRANT: begin
          if (transfer) begin
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
            if (last_beat) begin
              last_grant_reg <= grant_reg;
              state_reg      <= IDLE;
            end
          end else if (!granted_valid) begin
            // Requester withdrew; release so others get a turn.
            last_grant_reg <= grant_reg;
            state_reg      <= IDLE;
          end
          // Valid but full: hold grant and burst count until space frees.
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) rd_underflow_reg <= 1'b0;
    else if (rd_en && empty) rd_underflow_reg <= 1'b1;
  end

  assign rd_underflow = rd_underflow_reg;

  fifo_sync #(
    .WIDTH (DATA_W + ID_W),
    .SIZE  (SIZE)
  ) u_fifo (
    .clk        (clk),
    .aresetn    (aresetn),
    .wr_en      (transfer),
    .data_wr    (fifo_wr_data),
    .rd_en      (rd_en & ~empty),
    .data_rd    (fifo_rd_data),
    .data_count (data_count),
    .empty      (empty),
    .full       (full)
  );

  assign {id_rd, data_rd} = fifo_rd_data;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int DATA_W    = 10;
  localparam int SIZE      = 16;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 8;
  localparam int ID_W      = 2;

  logic                      clk = 1'b0;
  logic                      aresetn;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rd_en;
  logic [DATA_W-1:0]         data_rd;
  logic [ID_W-1:0]           id_rd;
  logic [4:0]                data_count;
  logic                      empty;
  logic                      full;
  logic                      rd_underflow;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          beat [NUM_REQ];
  logic [3:0]  xfer;
  logic        rd_ok;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA_W    (DATA_W),
    .SIZE      (SIZE),
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rd_en        (rd_en),
    .data_rd      (data_rd),
    .id_rd        (id_rd),
    .data_count   (data_count),
    .empty        (empty),
    .full         (full),
    .rd_underflow (rd_underflow)
  );

  // Requester k presents k*64 + (number of words it has delivered so far).
  task automatic refresh_data();
    for (int k = 0; k < NUM_REQ; k++)
      req_data[k*DATA_W +: DATA_W] = DATA_W'(k*64 + beat[k]);
  endtask

  // One clock: handshakes sampled mid-cycle, inputs updated #1 after the edge.
  task automatic step();
    @(negedge clk);
    xfer  = req_valid & req_ready;
    rd_ok = rd_en & ~empty;
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++)
      if (xfer[k]) beat[k] = beat[k] + 1;
    refresh_data();
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    req_valid = '0;
    rd_en     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) beat[k] = 0;
    refresh_data();
    step();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    step();
    n_cmp++;
    if (req_ready !== 4'b0000 || empty !== 1'b1 || full !== 1'b0 ||
        data_count !== 5'd0 || rd_underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: ready=%b empty=%b full=%b count=%0d unf=%b, want 0000 1 0 0 0",
               req_ready, empty, full, data_count, rd_underflow);
    end
    $display("reset: ready=%b empty=%b full=%b count=%0d", req_ready, empty, full, data_count);
  endtask

  task automatic test_single_fill();
    do_reset();
    req_valid = 4'b0100;
    step();
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++; $display("FAIL fill_first_ready: got %b want 0100", req_ready);
    end
    for (int c = 0; c < 8; c++) step();
    n_cmp++;
    if (req_ready !== 4'b0000 || data_count !== 5'd8) begin
      n_bad++; $display("FAIL fill_burst1: ready=%b count=%0d want 0000 8", req_ready, data_count);
    end
    step();
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++; $display("FAIL fill_regrant: got %b want 0100", req_ready);
    end
    for (int c = 0; c < 8; c++) step();
    for (int c = 0; c < 4; c++) step();
    n_cmp++;
    if (data_count !== 5'd16 || full !== 1'b1 || req_ready !== 4'b0000 || beat[2] != 16) begin
      n_bad++;
      $display("FAIL fill_full: count=%0d full=%b ready=%b writes=%0d want 16 1 0000 16",
               data_count, full, req_ready, beat[2]);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_cmp++;
    if (data_count !== 5'd15 || id_rd !== 2'd2 || data_rd !== 10'd128 || req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL fill_drain_one: count=%0d id=%0d data=%0d ready=%b want 15 2 128 0100",
               data_count, id_rd, data_rd, req_ready);
    end
    $display("single_fill: writes=%0d count=%0d ready=%b", beat[2], data_count, req_ready);
  endtask

  task automatic test_round_robin();
    int n;
    int exp_id;
    int exp_data;
    do_reset();
    req_valid = 4'b1111;
    rd_en     = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 40; c++) begin
      step();
      n_cmp++;
      if (data_count > 5'd16) begin
        n_bad++; $display("FAIL rr_count_bound: got %0d want <=16", data_count);
      end
      if (rd_ok) begin
        exp_id   = (n / 8) % 4;
        exp_data = exp_id*64 + (n / 32)*8 + (n % 8);
        n_cmp++;
        if (id_rd !== ID_W'(exp_id) || data_rd !== DATA_W'(exp_data)) begin
          n_bad++;
          $display("FAIL rr_word%0d: id=%0d data=%0d want id=%0d data=%0d",
                   n, id_rd, data_rd, exp_id, exp_data);
        end
        n++;
      end
    end
    n_cmp++;
    if (n != 40) begin
      n_bad++; $display("FAIL rr_timeout: got %0d reads want 40", n);
    end
    req_valid = '0;
    rd_en     = 1'b0;
    $display("round_robin: reads=%0d", n);
  endtask

  task automatic test_early_drop();
    int exp_id [4]   = '{0, 0, 0, 1};
    int exp_data [4] = '{0, 1, 2, 64};
    do_reset();
    req_valid = 4'b0011;
    for (int c = 0; c < 20 && beat[0] < 3; c++) step();
    n_cmp++;
    if (beat[0] != 3) begin
      n_bad++; $display("FAIL drop_timeout: got %0d words want 3", beat[0]);
    end
    req_valid = 4'b0010;
    step();
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_bad++; $display("FAIL drop_release: got %b want 0000", req_ready);
    end
    req_valid = 4'b0011;
    step();
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL drop_next_grant: got %b want 0010", req_ready);
    end
    step();
    req_valid = 4'b0000;
    n_cmp++;
    if (data_count !== 5'd4) begin
      n_bad++; $display("FAIL drop_count: got %0d want 4", data_count);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (!rd_ok || id_rd !== ID_W'(exp_id[i]) || data_rd !== DATA_W'(exp_data[i])) begin
        n_bad++;
        $display("FAIL drop_word%0d: ok=%b id=%0d data=%0d want id=%0d data=%0d",
                 i, rd_ok, id_rd, data_rd, exp_id[i], exp_data[i]);
      end
    end
    rd_en = 1'b0;
    $display("early_drop: req0 words=%0d req1 words=%0d", beat[0], beat[1]);
  endtask

  task automatic test_underflow();
    do_reset();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_cmp++;
    if (rd_underflow !== 1'b1 || data_count !== 5'd0) begin
      n_bad++; $display("FAIL unf_set: unf=%b count=%0d want 1 0", rd_underflow, data_count);
    end
    for (int c = 0; c < 3; c++) step();
    n_cmp++;
    if (rd_underflow !== 1'b1) begin
      n_bad++; $display("FAIL unf_sticky: got %b want 1", rd_underflow);
    end
    do_reset();
    n_cmp++;
    if (rd_underflow !== 1'b0) begin
      n_bad++; $display("FAIL unf_clear: got %b want 0", rd_underflow);
    end
    $display("underflow: flag=%b after reset", rd_underflow);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'b1000;
    for (int c = 0; c < 20 && beat[3] < 5; c++) step();
    n_cmp++;
    if (data_count !== 5'd5) begin
      n_bad++; $display("FAIL midrst_pre: count=%0d want 5", data_count);
    end
    aresetn = 1'b0;
    step();
    n_cmp++;
    if (data_count !== 5'd0 || empty !== 1'b1 || req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL midrst_clear: count=%0d empty=%b ready=%b want 0 1 0000",
               data_count, empty, req_ready);
    end
    aresetn   = 1'b1;
    req_valid = 4'b1001;
    step();
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL midrst_first_grant: got %b want 0001", req_ready);
    end
    req_valid = '0;
    $display("reset_mid_burst: ready=%b after release", req_ready);
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_round_robin();
    test_early_drop();
    test_underflow();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
